// File: rtl/moore_seq_pkg.sv
// -----------------------------------------------------------------------------
// moore_seq_pkg
// Shared definitions for the Moore sequence detector:
//   - default symbol width, pattern depth and match-counter width
//   - default reset pattern (symbol 0 in the LSBs is the first symbol expected)
//   - prog_w(): width needed to hold a progress value 0..depth
//   - action_t: what the detector does on a given clock edge
// No ports (package).
// -----------------------------------------------------------------------------
package moore_seq_pkg;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 8;

    // Pattern 1,2,1,2 with the first expected symbol in the least significant slot.
    localparam logic [DEF_WIDTH*DEF_DEPTH-1:0] DEF_PATTERN_INIT = {3'd2, 3'd1, 3'd2, 3'd1};

    // Progress runs 0..depth inclusive, so it needs clog2(depth+1) bits.
    function automatic int prog_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Per-edge action once reset has been ruled out; load outranks a valid symbol.
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_LOAD  = 2'd1,
        ACT_SHIFT = 2'd2
    } action_t;

endpackage

// File: rtl/moore_seq_det_if.sv
// -----------------------------------------------------------------------------
// moore_seq_det_if
// Bundles the symbol stream, pattern load controls and detector outputs.
//   a_in        symbol to evaluate
//   valid_in    a_in is consumed only when high
//   pattern_in  replacement pattern, symbol k at [k*WIDTH +: WIDTH]
//   load_in     latch pattern_in and restart matching
//   overlap_in  1 = overlapping matches, 0 = restart after each hit
//   z_out       match flag (Moore, from state only)
//   state_out   current progress 0..DEPTH
//   count_out   saturating number of matches
// master: the stream source; slave: the detector.
// -----------------------------------------------------------------------------
interface moore_seq_det_if
    import moore_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
);
    localparam int PW = prog_w(DEPTH);

    logic [WIDTH-1:0]       a_in;
    logic                   valid_in;
    logic [WIDTH*DEPTH-1:0] pattern_in;
    logic                   load_in;
    logic                   overlap_in;
    logic                   z_out;
    logic [PW-1:0]          state_out;
    logic [CNT_W-1:0]       count_out;

    modport master (
        output a_in, valid_in, pattern_in, load_in, overlap_in,
        input  z_out, state_out, count_out
    );

    modport slave (
        input  a_in, valid_in, pattern_in, load_in, overlap_in,
        output z_out, state_out, count_out
    );

endinterface

// File: rtl/moore_prefix_match.sv
// -----------------------------------------------------------------------------
// moore_prefix_match
// Combinational: given the symbol history (newest symbol in slot 0, already
// including the symbol being evaluated), the pattern and the number of eligible
// symbols before that newest one, returns the longest k (1..min(DEPTH, elig+1))
// whose last k history symbols equal pattern symbols 0..k-1, or 0.
//   history   DEPTH symbols, slot 0 newest
//   pattern   DEPTH symbols, slot 0 first expected
//   elig      eligible history count before the newest symbol
//   progress  resulting progress value
// -----------------------------------------------------------------------------
module moore_prefix_match
    import moore_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PW    = prog_w(DEPTH)
) (
    input  logic [WIDTH*DEPTH-1:0] history,
    input  logic [WIDTH*DEPTH-1:0] pattern,
    input  logic [PW-1:0]          elig,
    output logic [PW-1:0]          progress
);

    logic hit;

    // Try every candidate length in ascending order; a later (longer) hit
    // overwrites an earlier one, so the longest matching prefix wins.
    // For length k, pattern symbol j lines up with history slot k-1-j.
    always_comb begin
        progress = '0;
        hit      = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            hit = (k <= int'(elig) + 1);
            for (int j = 0; j < DEPTH; j++) begin
                if (j < k &&
                    pattern[j*WIDTH +: WIDTH] != history[((j < k) ? (k - 1 - j) : 0)*WIDTH +: WIDTH]) begin
                    hit = 1'b0;
                end
            end
            if (hit) begin
                progress = PW'(k);
            end
        end
    end

endmodule

// File: rtl/moore_seq_det.sv
// -----------------------------------------------------------------------------
// moore_seq_det
// Moore-style detector for a programmable DEPTH-symbol pattern in a stream of
// WIDTH-bit symbols, with optional overlapping matches and a saturating match
// counter.
//   clock   rising-edge clock
//   reset   synchronous, active-high; restores PATTERN_INIT and clears state
//   bus     moore_seq_det_if.slave (stream in, pattern load, match outputs)
// -----------------------------------------------------------------------------
module moore_seq_det
    import moore_seq_pkg::*;
#(
    parameter int                               WIDTH        = DEF_WIDTH,
    parameter int                               DEPTH        = DEF_DEPTH,
    parameter int                               CNT_W        = DEF_CNT_W,
    parameter logic [WIDTH*DEPTH-1:0]           PATTERN_INIT = DEF_PATTERN_INIT
) (
    input logic             clock,
    input logic             reset,
    moore_seq_det_if.slave  bus
);

    localparam int PW = prog_w(DEPTH);

    logic [WIDTH*DEPTH-1:0] pattern_q, pattern_d;
    logic [WIDTH*DEPTH-1:0] history_q, history_d;
    logic [WIDTH*DEPTH-1:0] history_shift;
    logic [PW-1:0]          progress_q, progress_d;
    logic [PW-1:0]          elig_q, elig_d;
    logic [PW-1:0]          elig_eff;
    logic [PW-1:0]          match_progress;
    logic [CNT_W-1:0]       count_q, count_d;
    action_t                action;

    // History as it would look after accepting a_in: newest symbol in slot 0,
    // oldest symbol falls off the top.
    assign history_shift = {history_q[WIDTH*(DEPTH-1)-1:0], bus.a_in};

    // In non-overlap mode a completed match forgets all prior history, so the
    // next symbol can only start a fresh match of length 1.
    assign elig_eff = (!bus.overlap_in && progress_q == PW'(DEPTH)) ? '0 : elig_q;

    moore_prefix_match #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_prefix_match (
        .history  (history_shift),
        .pattern  (pattern_q),
        .elig     (elig_eff),
        .progress (match_progress)
    );

    // State register; reset restores the power-up pattern but keeps nothing
    // of the stream seen so far.
    always_ff @(posedge clock) begin
        if (reset) begin
            pattern_q  <= PATTERN_INIT;
            history_q  <= '0;
            progress_q <= '0;
            elig_q     <= '0;
            count_q    <= '0;
        end else begin
            pattern_q  <= pattern_d;
            history_q  <= history_d;
            progress_q <= progress_d;
            elig_q     <= elig_d;
            count_q    <= count_d;
        end
    end

    // Next-state logic: load beats a valid symbol; with neither, everything
    // holds. The counter only moves on a valid symbol that completes a match
    // and sticks at its all-ones value.
    always_comb begin
        action     = ACT_HOLD;
        pattern_d  = pattern_q;
        history_d  = history_q;
        progress_d = progress_q;
        elig_d     = elig_q;
        count_d    = count_q;

        if (bus.load_in) begin
            action = ACT_LOAD;
        end else if (bus.valid_in) begin
            action = ACT_SHIFT;
        end

        case (action)
            ACT_LOAD: begin
                pattern_d  = bus.pattern_in;
                history_d  = '0;
                progress_d = '0;
                elig_d     = '0;
            end
            ACT_SHIFT: begin
                history_d  = history_shift;
                progress_d = match_progress;
                elig_d     = (elig_eff == PW'(DEPTH)) ? elig_eff : elig_eff + PW'(1);
                if (match_progress == PW'(DEPTH) && count_q != '1) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs come straight from registered state (Moore).
    assign bus.z_out     = (progress_q == PW'(DEPTH));
    assign bus.state_out = progress_q;
    assign bus.count_out = count_q;

endmodule

// File: tb/tb_moore_seq_det.sv
// -----------------------------------------------------------------------------
// tb_moore_seq_det
// Self-checking bench for moore_seq_det (WIDTH=3, DEPTH=4, CNT_W=2).
// A queue-based reference model predicts the outputs after every edge; the
// prediction goes into a scoreboard queue that a separate monitor drains on
// the falling edge. Directed scenarios also check against hand-derived values.
// -----------------------------------------------------------------------------
module tb_moore_seq_det;

    localparam int WIDTH = 3;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [WIDTH*DEPTH-1:0] PAT_1212 = {3'd2, 3'd1, 3'd2, 3'd1};
    localparam logic [WIDTH*DEPTH-1:0] PAT_5555 = {3'd5, 3'd5, 3'd5, 3'd5};

    typedef struct {
        logic z;
        int   st;
        int   cnt;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    exp_t exp_q[$];

    // Reference model state: the eligible symbols themselves, oldest first.
    int m_hist[$];
    int m_pat[DEPTH];
    int m_prog = 0;
    int m_cnt  = 0;

    moore_seq_det_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    moore_seq_det #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .CNT_W        (CNT_W),
        .PATTERN_INIT (PAT_1212)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Longest prefix of the pattern that ends the eligible history.
    function automatic int bestPrefix();
        int n;
        bit ok;
        n = m_hist.size();
        for (int k = n; k >= 1; k--) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (m_hist[n - k + j] != m_pat[j]) ok = 1'b0;
            end
            if (ok) return k;
        end
        return 0;
    endfunction

    task automatic loadModelPattern(input logic [WIDTH*DEPTH-1:0] pat);
        for (int k = 0; k < DEPTH; k++) m_pat[k] = int'(pat[k*WIDTH +: WIDTH]);
    endtask

    // Drive one cycle of inputs, advance the model over the edge and queue
    // the outputs the detector should show after that edge.
    task automatic applyStimulus(input logic rst, input logic v, input logic [WIDTH-1:0] a,
                                 input logic ld, input logic [WIDTH*DEPTH-1:0] pat,
                                 input logic ov);
        exp_t e;
        @(negedge clock);
        reset          = rst;
        bus.valid_in   = v;
        bus.a_in       = a;
        bus.load_in    = ld;
        bus.pattern_in = pat;
        bus.overlap_in = ov;
        @(posedge clock);
        if (rst) begin
            loadModelPattern(PAT_1212);
            m_hist.delete();
            m_prog = 0;
            m_cnt  = 0;
        end else if (ld) begin
            loadModelPattern(pat);
            m_hist.delete();
            m_prog = 0;
        end else if (v) begin
            if (!ov && m_prog == DEPTH) m_hist.delete();
            m_hist.push_back(int'(a));
            if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
            m_prog = bestPrefix();
            if (m_prog == DEPTH && m_cnt < CNT_MAX) m_cnt++;
        end
        e.z   = (m_prog == DEPTH);
        e.st  = m_prog;
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic sendSym(input int a, input logic ov);
        applyStimulus(1'b0, 1'b1, WIDTH'(a), 1'b0, '0, ov);
    endtask

    task automatic idle(input logic ov);
        applyStimulus(1'b0, 1'b0, WIDTH'(7), 1'b0, '0, ov);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    // Direct check against hand-derived values, sampled just after the edge.
    task automatic checkOutput(input string name, input logic ez, input int es, input int ec);
        #1;
        checks++;
        if (bus.z_out !== ez || bus.state_out !== 3'(es) || bus.count_out !== 2'(ec)) begin
            errors++;
            $display("[TB] FAIL %s: got z=%0b state=%0d count=%0d, expected z=%0b state=%0d count=%0d",
                     name, bus.z_out, bus.state_out, bus.count_out, ez, es, ec);
        end
    endtask

    // Scoreboard monitor: one prediction per edge, compared mid-cycle.
    always @(negedge clock) begin
        cycle++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.z_out !== e.z || bus.state_out !== 3'(e.st) || bus.count_out !== 2'(e.cnt)) begin
                errors++;
                $display("[TB] FAIL scoreboard cycle %0d: got z=%0b state=%0d count=%0d, expected z=%0b state=%0d count=%0d",
                         cycle, bus.z_out, bus.state_out, bus.count_out, e.z, e.st, e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seq_fb[7];
        int st_fb[7];
        seq_fb = '{1, 2, 1, 1, 2, 1, 2};
        st_fb  = '{1, 2, 3, 1, 2, 3, 4};

        bus.a_in       = '0;
        bus.valid_in   = 1'b0;
        bus.pattern_in = '0;
        bus.load_in    = 1'b0;
        bus.overlap_in = 1'b1;
        loadModelPattern(PAT_1212);

        $display("[TB] reset state");
        doReset();
        checkOutput("reset", 1'b0, 0, 0);

        $display("[TB] overlapping stream 1,2,1,2,1,2");
        sendSym(1, 1'b1); sendSym(2, 1'b1); sendSym(1, 1'b1); sendSym(2, 1'b1);
        checkOutput("overlap_4th", 1'b1, 4, 1);
        sendSym(1, 1'b1);
        checkOutput("overlap_5th", 1'b0, 3, 1);
        sendSym(2, 1'b1);
        checkOutput("overlap_6th", 1'b1, 4, 2);

        $display("[TB] non-overlapping stream 1,2,1,2,1,2,1,2");
        doReset();
        for (int r = 0; r < 2; r++) begin
            sendSym(1, 1'b0); sendSym(2, 1'b0); sendSym(1, 1'b0);
            checkOutput("nonoverlap_3rd", 1'b0, 3, r);
            sendSym(2, 1'b0);
            checkOutput("nonoverlap_4th", 1'b1, 4, r + 1);
            if (r == 0) begin
                sendSym(1, 1'b0); sendSym(2, 1'b0);
                checkOutput("nonoverlap_6th", 1'b0, 2, 1);
                sendSym(1, 1'b0); sendSym(2, 1'b0);
                checkOutput("nonoverlap_8th", 1'b1, 4, 2);
                break;
            end
        end

        $display("[TB] fallback stream 1,2,1,1,2,1,2");
        doReset();
        for (int i = 0; i < 7; i++) begin
            sendSym(seq_fb[i], 1'b1);
            checkOutput($sformatf("fallback_%0d", i + 1), st_fb[i] == 4, st_fb[i], (i == 6) ? 1 : 0);
        end

        $display("[TB] valid gaps");
        doReset();
        sendSym(1, 1'b1); sendSym(2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            checkOutput("gap_hold_partial", 1'b0, 2, 0);
        end
        sendSym(1, 1'b1); sendSym(2, 1'b1);
        checkOutput("gap_match", 1'b1, 4, 1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            checkOutput("gap_hold_match", 1'b1, 4, 1);
        end

        $display("[TB] reload pattern 5,5,5,5");
        doReset();
        sendSym(1, 1'b1); sendSym(2, 1'b1); sendSym(1, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'd2, 1'b1, PAT_5555, 1'b1);
        checkOutput("load_clear", 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) sendSym(5, 1'b1);
        checkOutput("load_partial", 1'b0, 3, 0);
        sendSym(5, 1'b1);
        checkOutput("load_match", 1'b1, 4, 1);

        $display("[TB] reset mid-sequence");
        doReset();
        sendSym(1, 1'b1); sendSym(2, 1'b1); sendSym(1, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'd2, 1'b0, '0, 1'b1);
        checkOutput("reset_mid", 1'b0, 0, 0);
        sendSym(2, 1'b1);
        checkOutput("reset_mid_after", 1'b0, 0, 0);

        $display("[TB] counter saturation");
        doReset();
        sendSym(1, 1'b1); sendSym(2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            sendSym(1, 1'b1); sendSym(2, 1'b1);
        end
        checkOutput("saturate", 1'b1, 4, CNT_MAX);

        $display("[TB] randomized traffic");
        doReset();
        for (int i = 0; i < 600; i++) begin
            int r;
            logic rst, ld, v, ov;
            logic [WIDTH-1:0] a;
            logic [WIDTH*DEPTH-1:0] pat;
            r   = $urandom_range(0, 199);
            rst = (r < 2);
            ld  = (r >= 2 && r < 8);
            v   = ($urandom_range(0, 3) != 0);
            ov  = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 4) == 0) a = WIDTH'($urandom_range(0, 7));
            else                           a = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd2;
            for (int k = 0; k < DEPTH; k++)
                pat[k*WIDTH +: WIDTH] = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd2;
            applyStimulus(rst, v, a, ld, pat, ov);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/moore_seq_det.md
MOORE_SEQ_DET -- requirements
Module: moore_seq_det

Interface
REQ-001 Parameter WIDTH, default 3: symbol width in bits.
REQ-002 Parameter DEPTH, default 4: pattern length in symbols, legal range 2..8.
REQ-003 Parameter CNT_W, default 8: width of the match counter.
REQ-004 Parameter PATTERN_INIT, default {3'd2,3'd1,3'd2,3'd1}: reset pattern; symbol 0 in the LSBs is the first symbol expected.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 a_in  input  WIDTH  incoming symbol.
REQ-008 valid_in  input  1  a_in is sampled only when high.
REQ-009 pattern_in  input  WIDTH*DEPTH  new pattern; symbol k occupies bits [k*WIDTH +: WIDTH].
REQ-010 load_in  input  1  latches pattern_in on the rising edge.
REQ-011 overlap_in  input  1  1 = overlapping matches allowed; 0 = matching restarts after each hit.
REQ-012 z_out  output  1  match indication (Moore).
REQ-013 state_out  output  clog2(DEPTH+1)  current progress value.
REQ-014 count_out  output  CNT_W  number of matches detected, saturating.

Function
REQ-015 State register progress SHALL hold 0..DEPTH, the length of the longest suffix of the eligible symbol history that equals pattern symbols 0..progress-1.
REQ-016 Per edge with valid_in=1: the history shifts in a_in, and the next progress is the largest k in 1..min(DEPTH, elig+1) whose last k symbols equal pattern[0..k-1], else 0.
REQ-017 elig is the count of eligible history symbols, 0..DEPTH, saturating; it increments on each valid symbol.
REQ-018 overlap_in=0 with progress==DEPTH: the next valid symbol SHALL be evaluated with elig treated as 0, so only k=1 or 0 is possible.
REQ-019 valid_in=0: progress, history, elig and count SHALL hold.
REQ-020 z_out SHALL equal (progress==DEPTH), decoded from the state register only, with no a_in path.
REQ-021 z_out latency: high in the cycle after the edge that samples the completing symbol.
REQ-022 z_out stays high while valid_in=0 holds the state at DEPTH.
REQ-023 count_out SHALL increment on each edge where next progress==DEPTH and valid_in=1.
REQ-024 count_out SHALL saturate at 2^CNT_W-1, with no wrap.
REQ-025 state_out SHALL equal progress.
REQ-026 load_in=1 SHALL latch pattern_in and clear progress, elig and history; a_in is ignored that cycle; count_out is unaffected.
REQ-027 Priority on the same edge: reset > load_in > valid_in.
REQ-028 overlap_in SHALL be sampled per edge; a change mid-stream affects only subsequent evaluations.

Reset
REQ-029 On reset the pattern SHALL be set to PATTERN_INIT; progress, elig, history and count_out SHALL be cleared; z_out SHALL be 0 from the next cycle.
REQ-030 Reset asserted mid-sequence SHALL discard the partial match, so no match is reported from pre-reset symbols.

Structure
REQ-031 Package moore_seq_pkg SHALL hold the DEPTH/WIDTH defaults, the PATTERN_INIT default and the progress-width function.
REQ-032 Sub-module moore_prefix_match SHALL be a combinational block taking history, pattern and elig and producing the next progress; it is instantiated once.
REQ-033 Target size: 120-400 lines of RTL total.

Verification
All scenarios use WIDTH=3, DEPTH=4 and pattern 1,2,1,2.
REQ-034 overlap_in=1, valid stream 1,2,1,2,1,2 -> z_out high after the 4th and 6th symbols; count_out=2; state_out after the 6th symbol = 4.
REQ-035 overlap_in=0, stream 1,2,1,2,1,2,1,2 -> z_out high after the 4th and 8th symbols only; count_out=2.
REQ-036 Fallback, stream 1,2,1,1,2,1,2 -> state_out sequence 1,2,3,1,2,3,4; z_out after the 7th symbol only.
REQ-037 Valid gaps and reload:
- 1,2,(3 idle cycles),1,2 -> match, with z_out and state holding during the gaps.
- load_in pattern 5,5,5,5 after 1,2,1 -> state_out=0, then 5,5,5,5 -> match.
REQ-038 Reset between the 3rd and 4th symbol of 1,2,1,2 -> no match, count_out=0.
REQ-039 Saturation with CNT_W=2: 5 matches -> count_out=3.
